// File: rtl/pwm_capture.sv
// PWM period / high-time / duty-cycle capture with a serial 10-bit restoring divider.
// Optional no-edge timeout detection is compiled in with `define PWM_CAPTURE_TIMEOUT_EN.
module pwm_capture #(
    parameter int unsigned TIMEOUT_CYCLES = 100_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pwm_in,
    output logic [31:0] period,
    output logic [31:0] high_time,
    output logic [9:0]  duty_cycle,
    output logic        valid,
    output logic        timeout
);
    localparam logic [1:0] IDLE       = 2'd0;
    localparam logic [1:0] ARMED_HIGH = 2'd1;
    localparam logic [1:0] ARMED_LOW  = 2'd2;
    localparam logic [1:0] DIVIDE     = 2'd3;

`ifdef PWM_CAPTURE_TIMEOUT_EN
    localparam bit TIMEOUT_EN = 1'b1;
`else
    localparam bit TIMEOUT_EN = 1'b0;
`endif

    logic        sync1, sync2, dly;
    logic        rise, fall;
    logic [1:0]  state;
    logic [31:0] cnt, hs, ps, hs_div;
    logic [32:0] rem, rem_sh, rem_nx;
    logic [8:0]  quo;
    logic [9:0]  quo_nx;
    logic [3:0]  iter;
    logic        fell_div, fell_now;
    logic        bit_q;
    logic        timeout_hit;

    assign rise = sync2 & ~dly;
    assign fall = ~sync2 & dly;

    // One restoring-divide step: the remainder stays below ps, so the shift never overflows.
    assign rem_sh = rem << 1;
    assign bit_q  = rem_sh >= {1'b0, ps};
    assign rem_nx = bit_q ? rem_sh - {1'b0, ps} : rem_sh;
    assign quo_nx = {quo, bit_q};

    // Tracks whether the input is currently in its low phase while the divider runs.
    assign fell_now = fall | (fell_div & ~rise);

    assign timeout_hit = TIMEOUT_EN && (state != IDLE) && (cnt >= TIMEOUT_CYCLES);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1      <= 1'b0;
            sync2      <= 1'b0;
            dly        <= 1'b0;
            state      <= IDLE;
            cnt        <= '0;
            hs         <= '0;
            ps         <= '0;
            hs_div     <= '0;
            rem        <= '0;
            quo        <= '0;
            iter       <= '0;
            fell_div   <= 1'b0;
            period     <= '0;
            high_time  <= '0;
            duty_cycle <= '0;
            valid      <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            sync1 <= pwm_in;
            sync2 <= sync1;
            dly   <= sync2;
            valid <= 1'b0;
            if (cnt != '1)
                cnt <= cnt + 32'd1;

            if (timeout_hit) begin
                state      <= IDLE;
                timeout    <= 1'b1;
                period     <= '0;
                high_time  <= '0;
                duty_cycle <= sync2 ? 10'h3FF : 10'h000;
                valid      <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        if (rise) begin
                            cnt   <= 32'd1;
                            state <= ARMED_HIGH;
                        end
                    end
                    ARMED_HIGH: begin
                        // A second rise without a fall means high >= period: restart the measurement.
                        if (rise)
                            cnt <= 32'd1;
                        else if (fall) begin
                            hs    <= cnt;
                            state <= ARMED_LOW;
                        end
                    end
                    ARMED_LOW: begin
                        if (rise) begin
                            ps       <= cnt;
                            cnt      <= 32'd1;
                            hs_div   <= hs;
                            rem      <= {1'b0, hs};
                            quo      <= '0;
                            iter     <= '0;
                            fell_div <= 1'b0;
                            state    <= DIVIDE;
                        end
                    end
                    default: begin
                        // Edges keep the counter tracking; a period completed here is dropped.
                        if (rise)
                            cnt <= 32'd1;
                        else if (fall)
                            hs <= cnt;
                        fell_div <= fell_now;
                        rem      <= rem_nx;
                        quo      <= quo_nx[8:0];
                        iter     <= iter + 4'd1;
                        if (iter == 4'd9) begin
                            period     <= ps;
                            high_time  <= hs_div;
                            duty_cycle <= quo_nx;
                            valid      <= 1'b1;
                            timeout    <= 1'b0;
                            state      <= fell_now ? ARMED_LOW : ARMED_HIGH;
                        end
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_pwm_capture.sv
// Self-checking bench for pwm_capture: pulse-level reference model with a scoreboard of
// expected measurements, checked on every valid and held values checked every other cycle.
module tb_pwm_capture;
    localparam int TO  = 1000;
    localparam int LAT = 13;   // input drive to valid: 2 synchronizer cycles + 11

    logic        clk = 1'b0;
    logic        reset;
    logic        pwm_in;
    logic [31:0] period, high_time;
    logic [9:0]  duty_cycle;
    logic        valid, timeout;

    pwm_capture #(.TIMEOUT_CYCLES(TO)) dut (
        .clk        (clk),
        .reset      (reset),
        .pwm_in     (pwm_in),
        .period     (period),
        .high_time  (high_time),
        .duty_cycle (duty_cycle),
        .valid      (valid),
        .timeout    (timeout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        longint p;
        longint h;
        longint d;
        logic   to;
        int     c;
    } exp_t;

    exp_t   q[$];
    int     checks = 0;
    int     errors = 0;
    logic   armed  = 1'b0;
    longint prev_h = 0;
    longint prev_p = 0;
    logic [31:0] last_p = '0, last_h = '0;
    logic [9:0]  last_d = '0;
    logic        last_to = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Model bookkeeping for a rising edge about to be driven: it completes the previous pulse.
    task automatic rise(input longint h, input longint p);
        if (armed)
            q.push_back('{prev_p, prev_h, (prev_h * 1024) / prev_p, 1'b0, cyc + LAT});
        armed  = 1'b1;
        prev_h = h;
        prev_p = p;
    endtask

    task automatic pulse(input int h, input int p);
        rise(h, p);
        pwm_in = 1'b1;
        step(h);
        pwm_in = 1'b0;
        step(p - h);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_period"}, period, 0);
        check({tag, "_high"}, high_time, 0);
        check({tag, "_duty"}, duty_cycle, 0);
        check({tag, "_valid"}, valid, 0);
        check({tag, "_timeout"}, timeout, 0);
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (valid === 1'b1) begin
            check("valid_expected", 64'(q.size() != 0), 64'd1);
            if (q.size() != 0) begin
                e = q.pop_front();
                check("period", period, e.p);
                check("high_time", high_time, e.h);
                check("duty_cycle", duty_cycle, e.d);
                check("timeout", timeout, e.to);
                check("latency_cycle", cyc, e.c);
                last_p  = 32'(e.p);
                last_h  = 32'(e.h);
                last_d  = 10'(e.d);
                last_to = e.to;
            end
        end else begin
            check("hold_period", period, last_p);
            check("hold_high", high_time, last_h);
            check("hold_duty", duty_cycle, last_d);
            check("hold_timeout", timeout, last_to);
        end
    end

    initial begin
        int p, h;
        reset  = 1'b0;
        pwm_in = 1'b0;
        step(3);
        check_zero("reset");
        reset = 1'b1;

        // Input stays low: no edges, nothing reported.
        step(50);

        repeat (4) pulse(25, 100);
        repeat (3) pulse(19, 20);
        pulse(1, 12);
        pulse(11, 12);
        pulse(10, 12);
        pulse(6, 12);
        pulse(25, 100);

        repeat (12) begin
            p = int'($urandom_range(300, 12));
            h = int'($urandom_range(p - 1, 1));
            pulse(h, p);
        end

        repeat (2) pulse(50, 100);
        repeat (3) pulse(150, 200);

        // Reset five cycles after the measuring rise is detected, with the divider running.
        pulse(4, 100);
        rise(4, 100);
        pwm_in = 1'b1;
        step(4);
        pwm_in = 1'b0;
        step(3);
        reset   = 1'b0;
        q.delete();
        armed   = 1'b0;
        last_p  = '0;
        last_h  = '0;
        last_d  = '0;
        last_to = 1'b0;
        step(1);
        check_zero("mid_divide_reset");
        step(1);
        reset = 1'b1;
        step(91);
        repeat (3) pulse(4, 100);

        // Input held high far beyond the timeout, then normal PWM resumes.
`ifdef PWM_CAPTURE_TIMEOUT_EN
        rise(1100, 1150);
        armed = 1'b0;
        q.push_back('{0, 0, 1023, 1'b1, cyc + TO + 3});
`else
        rise(1100, 1150);
`endif
        pwm_in = 1'b1;
        step(1100);
        pwm_in = 1'b0;
        step(50);
        repeat (3) pulse(50, 100);

        step(30);
        check("scoreboard_drained", 64'(q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
